// File: rtl/move_entry.sv
// Pick-15 human-input front end: button sync/debounce, move legality against the
// used-number mask, and one-cycle accepted-move / new-game pulses.
module move_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enter_L,
    input  logic       newGame_L,
    input  logic [3:0] hMove,
    input  logic [3:0] cMove,
    input  logic       cMove_valid,
    output logic       hMove_valid,
    output logic [3:0] hMove_out,
    output logic       illegal,
    output logic       newGame,
    output logic [8:0] used
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    // Button index 0 is enter, index 1 is newGame; all levels are active-low.
    logic [1:0]      sync1_q, sync1_d;
    logic [1:0]      sync2_q, sync2_d;
    logic [1:0]      db_q, db_d;
    logic [1:0]      db_prev_q, db_prev_d;
    logic [1:0][7:0] cnt_q, cnt_d;
    logic [1:0]      press;

    logic       hv_q, hv_d;
    logic [3:0] hout_q, hout_d;
    logic       ill_q, ill_d;
    logic       ng_q, ng_d;
    logic [8:0] used_q, used_d;
    logic [8:0] c_bit, h_bit, used_c;

    function automatic logic [8:0] num_bit(input logic [3:0] v);
        num_bit = '0;
        if (v >= 4'd1 && v <= 4'd9)
            num_bit = 9'd1 << (v - 4'd1);
    endfunction

    always_comb begin
        sync1_d   = {newGame_L, enter_L};
        sync2_d   = sync1_q;
        db_d      = db_q;
        db_prev_d = db_q;
        cnt_d     = cnt_q;
        for (int unsigned i = 0; i < 2; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    db_d[i]  = sync2_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 8'd1;
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    // Press event is the registered 1->0 edge of the debounced level.
    assign press = db_prev_q & ~db_q;

    always_comb begin
        c_bit  = cMove_valid ? num_bit(cMove) : '0;
        h_bit  = num_bit(hMove);
        used_c = used_q | c_bit;
        hv_d   = 1'b0;
        ng_d   = 1'b0;
        hout_d = hout_q;
        ill_d  = ill_q;
        used_d = used_c;
        if (press[1]) begin
            used_d = '0;
            ill_d  = 1'b0;
            ng_d   = 1'b1;
        end else if (press[0]) begin
            // A same-cycle computer move already counts as taken here.
            if (h_bit != '0 && (h_bit & used_c) == '0) begin
                hv_d   = 1'b1;
                hout_d = hMove;
                used_d = used_c | h_bit;
                ill_d  = 1'b0;
            end else begin
                ill_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            db_q      <= '1;
            db_prev_q <= '1;
            cnt_q     <= '0;
            hv_q      <= 1'b0;
            hout_q    <= '0;
            ill_q     <= 1'b0;
            ng_q      <= 1'b0;
            used_q    <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            cnt_q     <= cnt_d;
            hv_q      <= hv_d;
            hout_q    <= hout_d;
            ill_q     <= ill_d;
            ng_q      <= ng_d;
            used_q    <= used_d;
        end
    end

    assign hMove_valid = hv_q;
    assign hMove_out   = hout_q;
    assign illegal     = ill_q;
    assign newGame     = ng_q;
    assign used        = used_q;

endmodule

// File: tb/tb_move_entry.sv
// Directed bench for move_entry: expected pulses are queued with their cycle and
// checked by an independent monitor; settled state is checked after each step.
module tb_move_entry;

    localparam int D = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enter_L = 1'b1;
    logic       newGame_L = 1'b1;
    logic [3:0] hMove = '0;
    logic [3:0] cMove = '0;
    logic       cMove_valid = 1'b0;
    logic       hMove_valid;
    logic [3:0] hMove_out;
    logic       illegal;
    logic       newGame;
    logic [8:0] used;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int         cyc;
        logic [1:0] kind;   // {newGame, hMove_valid}
        logic [3:0] hout;
        logic [8:0] used;
        logic       ill;
    } exp_t;

    exp_t sb[$];

    move_entry #(.DEBOUNCE_CYCLES(D)) dut (
        .clock(clock), .reset(reset), .enter_L(enter_L), .newGame_L(newGame_L),
        .hMove(hMove), .cMove(cMove), .cMove_valid(cMove_valid),
        .hMove_valid(hMove_valid), .hMove_out(hMove_out), .illegal(illegal),
        .newGame(newGame), .used(used)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    always @(negedge clock) begin
        if (hMove_valid || newGame) begin
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse cyc=%0d got kind=%b hout=%0d", cyc, {newGame, hMove_valid}, hMove_out);
            end else begin
                e = sb.pop_front();
                if (cyc != e.cyc || {newGame, hMove_valid} != e.kind || hMove_out != e.hout ||
                    used != e.used || illegal != e.ill) begin
                    errors++;
                    $display("FAIL pulse got cyc=%0d kind=%b hout=%0d used=%h ill=%b expected cyc=%0d kind=%b hout=%0d used=%h ill=%b",
                             cyc, {newGame, hMove_valid}, hMove_out, used, illegal,
                             e.cyc, e.kind, e.hout, e.used, e.ill);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic state(input string name, input logic [3:0] eh, input logic [8:0] eu, input logic ei);
        chk({name, "_hout"}, int'(hMove_out), int'(eh));
        chk({name, "_used"}, int'(used), int'(eu));
        chk({name, "_illegal"}, int'(illegal), int'(ei));
    endtask

    // Hold enter (and optionally newGame) low for a full press, then release.
    task automatic press(input string name, input logic [3:0] hm, input bit pulse,
                         input logic [1:0] kind, input logic [3:0] eh, input logic [8:0] eu,
                         input logic ei, input bit with_c, input logic [3:0] cm, input bit with_ng);
        int e;
        exp_t x;
        @(negedge clock);
        hMove   = hm;
        enter_L = 1'b0;
        if (with_ng) newGame_L = 1'b0;
        e = cyc + 3 + D;
        if (pulse) begin
            x.cyc = e; x.kind = kind; x.hout = eh; x.used = eu; x.ill = ei;
            sb.push_back(x);
        end
        for (int k = 0; k < D + 8; k++) begin
            @(negedge clock);
            cMove       = cm;
            cMove_valid = with_c && (cyc == e - 1);
        end
        cMove_valid = 1'b0;
        enter_L     = 1'b1;
        newGame_L   = 1'b1;
        repeat (D + 6) @(negedge clock);
        state(name, eh, eu, ei);
    endtask

    task automatic cmove(input logic [3:0] v);
        @(negedge clock);
        cMove = v;
        cMove_valid = 1'b1;
        @(negedge clock);
        cMove_valid = 1'b0;
    endtask

    initial begin
        int e;
        exp_t x;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("reset_valid", int'(hMove_valid), 0);
        chk("reset_newgame", int'(newGame), 0);
        state("reset", 4'd0, 9'h000, 1'b0);

        press("move6", 4'd6, 1, 2'b01, 4'd6, 9'h020, 1'b0, 0, 4'd0, 0);

        @(negedge clock);
        hMove = 4'd2; enter_L = 1'b0;
        repeat (3) @(negedge clock);
        enter_L = 1'b1;
        repeat (D + 6) @(negedge clock);
        state("glitch", 4'd6, 9'h020, 1'b0);

        cmove(4'd5);
        chk("cmove5_used", int'(used), 'h030);
        press("taken5", 4'd5, 0, 2'b00, 4'd6, 9'h030, 1'b1, 0, 4'd0, 0);
        press("move9", 4'd9, 1, 2'b01, 4'd9, 9'h130, 1'b0, 0, 4'd0, 0);
        press("zero", 4'd0, 0, 2'b00, 4'd9, 9'h130, 1'b1, 0, 4'd0, 0);
        press("twelve", 4'd12, 0, 2'b00, 4'd9, 9'h130, 1'b1, 0, 4'd0, 0);
        cmove(4'd13);
        chk("cmove13_used", int'(used), 'h130);

        press("race3", 4'd3, 0, 2'b00, 4'd9, 9'h134, 1'b1, 1, 4'd3, 0);

        cmove(4'd1); cmove(4'd2); cmove(4'd4); cmove(4'd7); cmove(4'd8);
        chk("full_used", int'(used), 'h1FF);
        press("full", 4'd1, 0, 2'b00, 4'd9, 9'h1FF, 1'b1, 0, 4'd0, 0);
        press("newgame", 4'd4, 1, 2'b10, 4'd9, 9'h000, 1'b0, 1, 4'd5, 1);

        // Reset mid-debounce with enter held across deassertion.
        @(negedge clock);
        hMove = 4'd7; enter_L = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("midrst_valid", int'(hMove_valid), 0);
        chk("midrst_newgame", int'(newGame), 0);
        state("midrst", 4'd0, 9'h000, 1'b0);
        reset = 1'b0;
        e = cyc + 3 + D;
        x.cyc = e; x.kind = 2'b01; x.hout = 4'd7; x.used = 9'h040; x.ill = 1'b0;
        sb.push_back(x);
        repeat (D + 8) @(negedge clock);
        enter_L = 1'b1;
        repeat (D + 6) @(negedge clock);
        state("postrst", 4'd7, 9'h040, 1'b0);

        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
